// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer (fetch/decode/exec/mem/wb) for the 8-bit CPU with memory timeout fault.
// Optional single-step mode: define SINGLE_STEP_EN to add the step input and stop at every instruction boundary.
module multicycle_sequencer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       run,
  input  logic [1:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       mem_addr_src,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       alusrc,
  output logic       aluop,
  output logic       regwrite,
  output logic       regdst,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [1:0] OP_R  = 2'b00;
  localparam logic [1:0] OP_LD = 2'b01;
  localparam logic [1:0] OP_ST = 2'b10;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);

  state_t            cur_state;
  state_t            nxt_state;
  state_t            boundary_state;
  logic [1:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              start;
  logic              timeout;

`ifdef SINGLE_STEP_EN
  logic step_d;
  logic step_pulse;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) step_d <= 1'b0;
    else        step_d <= step;
  end

  assign step_pulse     = step & ~step_d;
  assign start          = run & step_pulse;
  assign boundary_state = S_IDLE;
`else
  assign start          = run;
  assign boundary_state = run ? S_FETCH : S_IDLE;
`endif

  // The request is still driven on the timeout cycle; a late ready on that cycle wins.
  assign timeout = (wait_cnt == WAIT_LIM) && !mem_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cur_state <= S_IDLE;
      op_q      <= 2'b00;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_DECODE) op_q <= opcode;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt <= '0;
    end else if ((nxt_state == S_FETCH || nxt_state == S_MEM) && nxt_state != cur_state) begin
      wait_cnt <= '0;
    end else if ((cur_state == S_FETCH || cur_state == S_MEM) && !mem_ready
                 && wait_cnt != WAIT_LIM) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ir_write     = 1'b0;
    mem_addr_src = 1'b0;
    memread      = 1'b0;
    memwrite     = 1'b0;
    memtoreg     = 1'b0;
    alusrc       = 1'b0;
    aluop        = 1'b0;
    regwrite     = 1'b0;
    regdst       = 1'b0;
    fault        = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (start) nxt_state = S_FETCH;
      end
      S_FETCH: begin
        memread = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nxt_state = S_DECODE;
        end else if (timeout) begin
          nxt_state = S_FAULT;
        end
      end
      S_DECODE: begin
        nxt_state = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_R: begin
            aluop     = 1'b1;
            nxt_state = S_WB;
          end
          OP_LD, OP_ST: begin
            alusrc    = 1'b1;
            nxt_state = S_MEM;
          end
          default: begin
            pc_src    = 1'b1;
            pc_write  = zero;
            nxt_state = boundary_state;
          end
        endcase
      end
      S_MEM: begin
        mem_addr_src = 1'b1;
        alusrc       = 1'b1;
        memread      = (op_q == OP_LD);
        memwrite     = (op_q == OP_ST);
        if (mem_ready) begin
          nxt_state = (op_q == OP_LD) ? S_WB : boundary_state;
        end else if (timeout) begin
          nxt_state = S_FAULT;
        end
      end
      S_WB: begin
        regwrite  = 1'b1;
        regdst    = (op_q == OP_R);
        memtoreg  = (op_q == OP_LD);
        nxt_state = boundary_state;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer (default parameters).
// Output vector bit order: pc_write pc_src ir_write mem_addr_src memread memwrite memtoreg alusrc aluop regwrite regdst fault.
module tb_multicycle_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       run;
  logic [1:0] opcode;
  logic       zero;
  logic       mem_ready;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif
  logic       pc_write, pc_src, ir_write, mem_addr_src, memread, memwrite;
  logic       memtoreg, alusrc, aluop, regwrite, regdst, fault;
  logic [2:0] state;
  logic [11:0] outs;

  int checks   = 0;
  int failures = 0;

  multicycle_sequencer #(.MEM_WAIT_MAX(15), .WAIT_W(8)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .run          (run),
    .opcode       (opcode),
    .zero         (zero),
    .mem_ready    (mem_ready),
`ifdef SINGLE_STEP_EN
    .step         (step),
`endif
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .ir_write     (ir_write),
    .mem_addr_src (mem_addr_src),
    .memread      (memread),
    .memwrite     (memwrite),
    .memtoreg     (memtoreg),
    .alusrc       (alusrc),
    .aluop        (aluop),
    .regwrite     (regwrite),
    .regdst       (regdst),
    .fault        (fault),
    .state        (state)
  );

  always #5 CLK = ~CLK;

  assign outs = {pc_write, pc_src, ir_write, mem_addr_src, memread, memwrite,
                 memtoreg, alusrc, aluop, regwrite, regdst, fault};

  // Expected output vectors
  localparam logic [11:0] O_NONE   = 12'h000;
  localparam logic [11:0] O_FET_R  = 12'hA80;
  localparam logic [11:0] O_FET_W  = 12'h080;
  localparam logic [11:0] O_EX_R   = 12'h008;
  localparam logic [11:0] O_EX_LS  = 12'h010;
  localparam logic [11:0] O_WB_R   = 12'h006;
  localparam logic [11:0] O_MEM_LD = 12'h190;
  localparam logic [11:0] O_MEM_ST = 12'h150;
  localparam logic [11:0] O_WB_LD  = 12'h024;
  localparam logic [11:0] O_BR_T   = 12'hC00;
  localparam logic [11:0] O_BR_N   = 12'h400;
  localparam logic [11:0] O_FAULT  = 12'h001;

  task automatic do_reset();
    RST_N = 1'b0; run = 1'b0; opcode = 2'b00; zero = 1'b0; mem_ready = 1'b0;
`ifdef SINGLE_STEP_EN
    step = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; run = 1'b1; opcode = 2'b11; zero = 1'b1; mem_ready = 1'b1;
`ifdef SINGLE_STEP_EN
    step = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #2;
      checks++;
      if (state !== 3'd0 || outs !== O_NONE) begin
        failures++;
        $display("FAIL reset[%0d] state=%0d outs=%h expected state=0 outs=%h", i, state, outs, O_NONE);
      end
    end
    do_reset();
    #1;
    checks++;
    if (state !== 3'd0 || outs !== O_NONE) begin
      failures++;
      $display("FAIL reset_release state=%0d outs=%h expected state=0 outs=%h", state, outs, O_NONE);
    end
  endtask

  task automatic test_rtype();
    int es [5] = '{1, 2, 3, 5, 1};
    logic [11:0] eo [5] = '{O_FET_R, O_NONE, O_EX_R, O_WB_R, O_FET_R};
    int irc = 0;
    int pcc = 0;
    do_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #2;
      if (i < 4) begin
        irc += int'(ir_write);
        pcc += int'(pc_write);
      end
      checks++;
      if (state !== 3'(es[i]) || outs !== eo[i]) begin
        failures++;
        $display("FAIL rtype[%0d] state=%0d outs=%h expected state=%0d outs=%h", i, state, outs, es[i], eo[i]);
      end
    end
    checks++;
    if (irc !== 1 || pcc !== 1) begin
      failures++;
      $display("FAIL rtype_pulses ir_write=%0d pc_write=%0d expected 1 and 1", irc, pcc);
    end
  endtask

  task automatic test_load_wait();
    int rdy [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    int es  [9] = '{1, 2, 3, 4, 4, 4, 4, 5, 1};
    logic [11:0] eo [9] = '{O_FET_R, O_NONE, O_EX_LS, O_MEM_LD, O_MEM_LD, O_MEM_LD,
                            O_MEM_LD, O_WB_LD, O_FET_R};
    do_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = 2'b01;
    for (int i = 0; i < 9; i++) begin
      @(posedge CLK); #1;
      mem_ready = rdy[i][0];
      #1;
      checks++;
      if (state !== 3'(es[i]) || outs !== eo[i]) begin
        failures++;
        $display("FAIL load_wait[%0d] state=%0d outs=%h expected state=%0d outs=%h", i, state, outs, es[i], eo[i]);
      end
    end
  endtask

  task automatic test_branch();
    int zr [7] = '{1, 1, 1, 0, 0, 0, 0};
    int es [7] = '{1, 2, 3, 1, 2, 3, 1};
    logic [11:0] eo [7] = '{O_FET_R, O_NONE, O_BR_T, O_FET_R, O_NONE, O_BR_N, O_FET_R};
    do_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = 2'b11;
    for (int i = 0; i < 7; i++) begin
      @(posedge CLK); #1;
      zero = zr[i][0];
      #1;
      checks++;
      if (state !== 3'(es[i]) || outs !== eo[i]) begin
        failures++;
        $display("FAIL branch[%0d] state=%0d outs=%h expected state=%0d outs=%h", i, state, outs, es[i], eo[i]);
      end
    end
  endtask

  task automatic test_store_timeout();
    int memcnt = 0;
    do_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = 2'b10;
    repeat (3) @(posedge CLK);
    #1 mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 3'd3 || outs !== O_EX_LS) begin
      failures++;
      $display("FAIL store_exec state=%0d outs=%h expected state=3 outs=%h", state, outs, O_EX_LS);
    end
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK); #2;
      if (state === 3'd4 && outs === O_MEM_ST) memcnt++;
    end
    checks++;
    if (memcnt !== 16) begin
      failures++;
      $display("FAIL store_mem_cycles got=%0d expected=16", memcnt);
    end
    @(posedge CLK); #2;
    checks++;
    if (state !== 3'd7 || outs !== O_FAULT) begin
      failures++;
      $display("FAIL store_fault state=%0d outs=%h expected state=7 outs=%h", state, outs, O_FAULT);
    end
    mem_ready = 1'b1; run = 1'b1;
    repeat (4) @(posedge CLK);
    #2;
    checks++;
    if (state !== 3'd7 || outs !== O_FAULT) begin
      failures++;
      $display("FAIL fault_sticky state=%0d outs=%h expected state=7 outs=%h", state, outs, O_FAULT);
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || outs !== O_NONE) begin
      failures++;
      $display("FAIL async_reset state=%0d outs=%h expected state=0 outs=%h", state, outs, O_NONE);
    end
  endtask

  task automatic test_timeout_edge();
    int fetcnt = 0;
    do_reset();
    run = 1'b1; mem_ready = 1'b0; opcode = 2'b00;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK); #2;
      if (state === 3'd1 && outs === O_FET_W) fetcnt++;
    end
    @(posedge CLK); #1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (fetcnt !== 15 || state !== 3'd1 || outs !== O_FET_R) begin
      failures++;
      $display("FAIL fetch_ready_last waits=%0d state=%0d outs=%h expected 15/1/%h", fetcnt, state, outs, O_FET_R);
    end
    @(posedge CLK); #2;
    checks++;
    if (state !== 3'd2 || fault !== 1'b0) begin
      failures++;
      $display("FAIL fetch_no_fault state=%0d fault=%b expected state=2 fault=0", state, fault);
    end
  endtask

  task automatic test_run_drop();
    int rn  [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    int rdy [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    int es  [9] = '{1, 2, 3, 4, 4, 5, 0, 0, 1};
    logic [11:0] eo [9] = '{O_FET_R, O_NONE, O_EX_LS, O_MEM_LD, O_MEM_LD, O_WB_LD,
                            O_NONE, O_NONE, O_FET_R};
    do_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = 2'b01;
    for (int i = 0; i < 9; i++) begin
      @(posedge CLK); #1;
      run = rn[i][0];
      mem_ready = rdy[i][0];
      #1;
      checks++;
      if (state !== 3'(es[i]) || outs !== eo[i]) begin
        failures++;
        $display("FAIL run_drop[%0d] state=%0d outs=%h expected state=%0d outs=%h", i, state, outs, es[i], eo[i]);
      end
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    int irc;
    do_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = 2'b00;
    for (int p = 0; p < 2; p++) begin
      irc = 0;
      @(posedge CLK); #1;
      step = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(posedge CLK); #1;
        step = 1'b0;
        #1;
        irc += int'(ir_write);
      end
      checks++;
      if (irc !== 1 || state !== 3'd0) begin
        failures++;
        $display("FAIL step_pulse[%0d] ir_write=%0d state=%0d expected 1 and 0", p, irc, state);
      end
    end
    irc = 0;
    @(posedge CLK); #1;
    step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #2;
      irc += int'(ir_write);
    end
    checks++;
    if (irc !== 1 || state !== 3'd0) begin
      failures++;
      $display("FAIL step_held ir_write=%0d state=%0d expected 1 and 0", irc, state);
    end
    step = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_store_timeout();
    test_timeout_edge();
`ifndef SINGLE_STEP_EN
    test_run_drop();
`else
    test_single_step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM controller for the 8-bit CPU datapath with the 2-bit opcode ISA: 00 R-type ALU, 01 load, 10 store, 11 branch.
- Replaces single-cycle control decode. Sequences fetch / decode / execute / memory / writeback over shared instruction+data memory with a ready handshake.
- Drives PC, IR, ALU, register-file and memory strobes each cycle. Flags a fault on memory timeout.

Parameters:
- MEM_WAIT_MAX, 15, max consecutive not-ready cycles tolerated in FETCH or MEM before FAULT (1..255).
- WAIT_W, 8, width of the wait counter; must hold MEM_WAIT_MAX.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- run  in  1  enable; sampled at instruction boundaries
- opcode  in  2  instruction[7:6] from IR; valid from DECODE onward
- zero  in  1  ALU zero flag (branch condition)
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  load PC
- pc_src  out  1  0 = PC+1, 1 = branch target
- ir_write  out  1  load IR from memory data
- mem_addr_src  out  1  0 = PC, 1 = ALU result
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- memtoreg  out  1  writeback data from memory
- alusrc  out  1  ALU B operand = immediate
- aluop  out  1  ALU function from funct field (R-type)
- regwrite  out  1  register file write enable
- regdst  out  1  destination = rd field
- fault  out  1  sticky memory timeout flag
- state  out  3  current state encoding, for debug

Behaviour:
- Interface: single clock CLK. RST_N is asynchronous and active-low.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7. State and op_q (latched opcode) are registered.
- Reset: state=IDLE, op_q=00, wait counter=0, fault=0. Every output is 0 while RST_N is low and in IDLE.
- Outputs are decoded combinationally from state, op_q, zero and mem_ready. Any output not listed for a state is 0.
- IDLE: if run=1 -> FETCH, else stay.
- FETCH:
  - memread=1, mem_addr_src=0.
  - In the cycle mem_ready=1: ir_write=1, pc_write=1, pc_src=0; -> DECODE.
- DECODE: op_q <= opcode at end of cycle. Unconditional -> EXEC.
- EXEC:
  - alusrc=1 for op_q 01/10; aluop=1 for op_q 00.
  - op_q 00 -> WB; 01 or 10 -> MEM.
  - op_q 11: pc_src=1, pc_write=zero; -> next-instruction boundary.
- MEM:
  - mem_addr_src=1, alusrc=1; memread=1 if op_q=01, memwrite=1 if op_q=10.
  - Hold until mem_ready=1. Then op_q 01 -> WB; op_q 10 -> boundary.
- WB:
  - regwrite=1; regdst=1 if op_q=00; memtoreg=1 if op_q=01.
  - -> boundary.
- Boundary: -> FETCH if run=1, else IDLE. run is ignored mid-instruction; dropping run never aborts an access.
- Latency with mem_ready tied high: R-type 4 cycles, load 5, store 4, branch 3 (taken or not).
- Wait counter:
  - Cleared on every entry to FETCH or MEM.
  - Increments each cycle in FETCH/MEM with mem_ready=0; saturates.
  - If counter == MEM_WAIT_MAX and mem_ready=0 -> FAULT next cycle. The timeout cycle itself still drives the request.
  - mem_ready=1 on the timeout cycle wins: normal transition, no fault.
- FAULT: fault=1, all strobes 0. Stays until RST_N asserted; run has no effect.
- Reset asserted mid-access: immediate return to IDLE with strobes 0. No partial PC or register update beyond edges already taken.
- Unused state encoding 6 -> IDLE on next edge, outputs 0.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit). A registered rising-edge detector on step produces step_pulse.
  - IDLE -> FETCH requires run=1 AND step_pulse.
  - Every instruction boundary goes to IDLE, so each step pulse executes exactly one instruction.
  - A step held high executes only one instruction.
- Undefined: no step port; boundary behaviour as specified above.

Test Plan:
- Reset, run=1, mem_ready=1, opcode=00 -> states 1,2,3,5,1. WB cycle has regwrite=1, regdst=1. ir_write and pc_write each pulse once per instruction.
- opcode=01, mem_ready low 3 cycles in MEM -> MEM held 4 cycles with memread=1, mem_addr_src=1. Then WB with memtoreg=1, regwrite=1.
- opcode=11: zero=1 -> EXEC has pc_write=1, pc_src=1. zero=0 -> pc_write=0. Both return to FETCH in 3 cycles.
- opcode=10, mem_ready=0 held in MEM, MEM_WAIT_MAX=15 -> memwrite=1 for 16 cycles, then FAULT, fault=1, strobes 0. fault stays 1 until RST_N low.
- run dropped during MEM of a load -> load completes WB, then IDLE. run=1 resumes at FETCH next cycle.
- SINGLE_STEP_EN, run=1: step pulsed twice -> exactly two instructions (two ir_write pulses), IDLE between them. step held high 20 cycles -> one instruction.
